// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one data RAM port between the CPU (port 0) and debug/loader (port 1)
//   clk, reset (async, active-high)
//   reqN_valid/ready/write/addr/wdata : request handshake per requester
//   rspN_valid/rdata                  : one-cycle completion pulse per requester
//   ram_address/write_enable/write_data, ram_data : RAM side
//   busy  : transaction in flight
//   owner : requester of current/last transaction
module ram_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_enable,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              owner
);
    localparam int CNT_W = RAM_LATENCY > 1 ? $clog2(RAM_LATENCY + 1) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic last_grant, lat_write, winner, accept;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata, rdata;
    logic [CNT_W-1:0] cnt;
    always_comb begin
        // A tie goes to whoever did not win last time.
        winner = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        accept = state == IDLE && (req0_valid || req1_valid) && !reset;
        req0_ready = accept && !winner;
        req1_ready = accept && winner;
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? ACCESS : IDLE;
            ACCESS:  state_nxt = (lat_write || RAM_LATENCY == 0) ? RESP : WAIT;
            WAIT:    state_nxt = cnt == CNT_W'(1) ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
        ram_address = (state == ACCESS || state == WAIT) ? lat_addr : '0;
        ram_write_enable = state == ACCESS && lat_write;
        ram_write_data = state == ACCESS ? lat_wdata : '0;
        rsp0_valid = state == RESP && !owner;
        rsp1_valid = state == RESP && owner;
        rsp0_rdata = rsp0_valid ? rdata : '0;
        rsp1_rdata = rsp1_valid ? rdata : '0;
        busy = state != IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= 1'b1;
            owner <= 1'b0;
            lat_write <= 1'b0;
            lat_addr <= '0;
            lat_wdata <= '0;
            rdata <= '0;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_write <= winner ? req1_write : req0_write;
                lat_addr <= winner ? req1_addr : req0_addr;
                lat_wdata <= winner ? req1_wdata : req0_wdata;
                owner <= winner;
                last_grant <= winner;
            end
            if (state == ACCESS) begin
                cnt <= CNT_W'(RAM_LATENCY);
                // Stores respond with zero; zero-latency loads capture here.
                if (lat_write || RAM_LATENCY == 0)
                    rdata <= lat_write ? '0 : ram_data;
            end
            if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1))
                    rdata <= ram_data;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter with a zero-latency RAM (dut_a) and a two-cycle RAM (dut_b)
module tb_ram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic a_rst, a_q0_valid, a_r0_ready, a_q0_write, a_q1_valid, a_r1_ready, a_q1_write;
    logic [9:0] a_q0_addr, a_q1_addr, a_addr;
    logic [31:0] a_q0_wdata, a_q1_wdata, a_rsp0_rdata, a_rsp1_rdata, a_wdata, a_ram_data;
    logic a_rsp0_valid, a_rsp1_valid, a_we, a_busy, a_owner;
    logic b_rst, b_q0_valid, b_r0_ready, b_q0_write, b_q1_valid, b_r1_ready, b_q1_write;
    logic [9:0] b_q0_addr, b_q1_addr, b_addr, b_d1, b_d2;
    logic [31:0] b_q0_wdata, b_q1_wdata, b_rsp0_rdata, b_rsp1_rdata, b_wdata, b_ram_data;
    logic b_rsp0_valid, b_rsp1_valid, b_we, b_busy, b_owner;
    logic pre_we_a, pre_we_b;
    logic [9:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    int checks = 0, errors = 0, we_cnt = 0, both_cnt = 0;

    ram_arbiter #(.ADDR_W(10), .DATA_W(32), .RAM_LATENCY(0)) dut_a (
        .clk(clk), .reset(a_rst),
        .req0_valid(a_q0_valid), .req0_ready(a_r0_ready), .req0_write(a_q0_write),
        .req0_addr(a_q0_addr), .req0_wdata(a_q0_wdata),
        .req1_valid(a_q1_valid), .req1_ready(a_r1_ready), .req1_write(a_q1_write),
        .req1_addr(a_q1_addr), .req1_wdata(a_q1_wdata),
        .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata),
        .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata),
        .ram_address(a_addr), .ram_write_enable(a_we), .ram_write_data(a_wdata),
        .ram_data(a_ram_data), .busy(a_busy), .owner(a_owner)
    );

    ram_arbiter #(.ADDR_W(10), .DATA_W(32), .RAM_LATENCY(2)) dut_b (
        .clk(clk), .reset(b_rst),
        .req0_valid(b_q0_valid), .req0_ready(b_r0_ready), .req0_write(b_q0_write),
        .req0_addr(b_q0_addr), .req0_wdata(b_q0_wdata),
        .req1_valid(b_q1_valid), .req1_ready(b_r1_ready), .req1_write(b_q1_write),
        .req1_addr(b_q1_addr), .req1_wdata(b_q1_wdata),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
        .ram_address(b_addr), .ram_write_enable(b_we), .ram_write_data(b_wdata),
        .ram_data(b_ram_data), .busy(b_busy), .owner(b_owner)
    );

    // Zero-latency RAM for dut_a; preload port used only while the DUT is idle.
    always @(posedge clk)
        if (a_we) mem_a[a_addr] <= a_wdata;
        else if (pre_we_a) mem_a[pre_addr] <= pre_data;
    assign a_ram_data = mem_a[a_addr];

    // Two-cycle RAM for dut_b: data reflects the address from two cycles earlier.
    always @(posedge clk) begin
        b_d1 <= b_addr;
        b_d2 <= b_d1;
        if (b_we) mem_b[b_addr] <= b_wdata;
        else if (pre_we_b) mem_b[pre_addr] <= pre_data;
    end
    assign b_ram_data = mem_b[b_d2];

    always @(negedge clk) begin
        if (a_we) we_cnt++;
        if (a_r0_ready && a_r1_ready) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit to_b, input logic [9:0] ad, input logic [31:0] d);
        pre_we_a = !to_b;
        pre_we_b = to_b;
        pre_addr = ad;
        pre_data = d;
        step();
        pre_we_a = 1'b0;
        pre_we_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int base, g, n;
        a_rst = 1'b1; b_rst = 1'b1;
        {a_q0_valid, a_q0_write, a_q1_valid, a_q1_write} = '0;
        {b_q0_valid, b_q0_write, b_q1_valid, b_q1_write} = '0;
        {a_q0_addr, a_q1_addr, b_q0_addr, b_q1_addr} = '0;
        {a_q0_wdata, a_q1_wdata, b_q0_wdata, b_q1_wdata} = '0;
        {pre_we_a, pre_we_b, pre_addr, pre_data} = '0;
        preload(0, 10'd10, 32'h1010_AAAA);
        preload(0, 10'd20, 32'h2020_BBBB);
        preload(0, 10'd7, 32'h0000_0055);
        preload(1, 10'd3, 32'h0000_1234);
        // reset state, ready suppressed while reset
        a_q0_valid = 1'b1; a_q1_valid = 1'b1;
        #1;
        check("rst_rdy0", 32'(a_r0_ready), 0);
        check("rst_rdy1", 32'(a_r1_ready), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_owner", 32'(a_owner), 0);
        check("rst_we", 32'(a_we), 0);
        check("rst_addr", 32'(a_addr), 0);
        check("rst_rsp0", 32'(a_rsp0_valid), 0);
        a_q0_valid = 1'b0; a_q1_valid = 1'b0;
        a_rst = 1'b0; b_rst = 1'b0;
        step();
        // test 1: port 0 store
        base = we_cnt;
        a_q0_valid = 1'b1; a_q0_write = 1'b1; a_q0_addr = 10'd5; a_q0_wdata = 32'hDEADBEEF;
        #1;
        check("t1_rdy0", 32'(a_r0_ready), 1);
        check("t1_rdy1", 32'(a_r1_ready), 0);
        check("t1_we_T", 32'(a_we), 0);
        step();
        a_q0_valid = 1'b0; a_q0_write = 1'b0;
        check("t1_we", 32'(a_we), 1);
        check("t1_addr", 32'(a_addr), 5);
        check("t1_wdata", a_wdata, 32'hDEADBEEF);
        check("t1_rsp0_early", 32'(a_rsp0_valid), 0);
        check("t1_busy", 32'(a_busy), 1);
        step();
        check("t1_we_T2", 32'(a_we), 0);
        check("t1_rsp0", 32'(a_rsp0_valid), 1);
        check("t1_rdata0", a_rsp0_rdata, 0);
        check("t1_rsp1", 32'(a_rsp1_valid), 0);
        step();
        check("t1_rsp0_after", 32'(a_rsp0_valid), 0);
        check("t1_idle", 32'(a_busy), 0);
        check("t1_we_count", 32'(we_cnt - base), 1);
        check("t1_mem", mem_a[5], 32'hDEADBEEF);
        // test 2: port 1 load of the stored word
        base = we_cnt;
        a_q1_valid = 1'b1; a_q1_addr = 10'd5;
        #1;
        check("t2_rdy1", 32'(a_r1_ready), 1);
        check("t2_rdy0", 32'(a_r0_ready), 0);
        step();
        a_q1_valid = 1'b0;
        check("t2_addr", 32'(a_addr), 5);
        check("t2_we", 32'(a_we), 0);
        step();
        check("t2_rsp1", 32'(a_rsp1_valid), 1);
        check("t2_rdata1", a_rsp1_rdata, 32'hDEADBEEF);
        check("t2_rsp0", 32'(a_rsp0_valid), 0);
        check("t2_owner", 32'(a_owner), 1);
        step();
        check("t2_rsp1_after", 32'(a_rsp1_valid), 0);
        check("t2_we_count", 32'(we_cnt - base), 0);
        // test 6: one-cycle req1 pulse while port 0 owns the RAM
        a_q0_valid = 1'b1; a_q0_addr = 10'd5;
        step();
        a_q0_valid = 1'b0;
        a_q1_valid = 1'b1; a_q1_addr = 10'd5;
        #1;
        check("t6_rdy1_busy", 32'(a_r1_ready), 0);
        step();
        a_q1_valid = 1'b0;
        check("t6_rsp0", 32'(a_rsp0_valid), 1);
        check("t6_rdata0", a_rsp0_rdata, 32'hDEADBEEF);
        check("t6_rsp1", 32'(a_rsp1_valid), 0);
        step();
        check("t6_idle", 32'(a_busy), 0);
        check("t6_rsp1_b", 32'(a_rsp1_valid), 0);
        step();
        check("t6_idle_b", 32'(a_busy), 0);
        check("t6_rsp1_c", 32'(a_rsp1_valid), 0);
        // test 3: both ports valid continuously from reset
        a_rst = 1'b1;
        #1;
        base = both_cnt;
        a_q0_valid = 1'b1; a_q0_addr = 10'd10;
        a_q1_valid = 1'b1; a_q1_addr = 10'd20;
        step();
        a_rst = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            g = -1;
            n = 0;
            while (g < 0 && n < 6) begin
                if (a_r0_ready) g = 0;
                else if (a_r1_ready) g = 1;
                else begin
                    step();
                    n++;
                end
            end
            check("t3_grant", 32'(g), 32'(k % 2));
            if (g < 0) break;
            step();
            step();
            check("t3_rsp_own", 32'(g == 0 ? a_rsp0_valid : a_rsp1_valid), 1);
            check("t3_rsp_other", 32'(g == 0 ? a_rsp1_valid : a_rsp0_valid), 0);
            check("t3_rdata", g == 0 ? a_rsp0_rdata : a_rsp1_rdata, g == 0 ? 32'h1010_AAAA : 32'h2020_BBBB);
            step();
        end
        a_q0_valid = 1'b0; a_q1_valid = 1'b0;
        check("t3_both_ready", 32'(both_cnt - base), 0);
        step();
        step();
        // test 5: reset in the ACCESS cycle of a store
        a_q0_valid = 1'b1; a_q0_write = 1'b1; a_q0_addr = 10'd7; a_q0_wdata = 32'h0000_00AA;
        #1;
        check("t5_rdy0", 32'(a_r0_ready), 1);
        step();
        a_q0_valid = 1'b0; a_q0_write = 1'b0;
        check("t5_we_pre", 32'(a_we), 1);
        a_rst = 1'b1;
        #1;
        check("t5_we", 32'(a_we), 0);
        check("t5_addr", 32'(a_addr), 0);
        check("t5_wdata", a_wdata, 0);
        check("t5_busy", 32'(a_busy), 0);
        check("t5_owner", 32'(a_owner), 0);
        step();
        check("t5_rsp0", 32'(a_rsp0_valid), 0);
        check("t5_rsp1", 32'(a_rsp1_valid), 0);
        check("t5_mem", mem_a[7], 32'h0000_0055);
        a_q0_valid = 1'b1; a_q0_addr = 10'd10;
        a_q1_valid = 1'b1; a_q1_addr = 10'd20;
        #1;
        check("t5_rdy_in_rst", 32'({a_r0_ready, a_r1_ready}), 0);
        a_rst = 1'b0;
        #1;
        check("t5_tie_rdy0", 32'(a_r0_ready), 1);
        check("t5_tie_rdy1", 32'(a_r1_ready), 0);
        a_q0_valid = 1'b0; a_q1_valid = 1'b0;
        step();
        // test 4: two-cycle RAM read on dut_b
        b_q0_valid = 1'b1; b_q0_addr = 10'd3;
        #1;
        check("t4_rdy0", 32'(b_r0_ready), 1);
        step();
        b_q0_valid = 1'b0;
        check("t4_busy", 32'(b_busy), 1);
        for (int i = 0; i < 3; i++) begin
            check("t4_addr", 32'(b_addr), 3);
            check("t4_rsp0_early", 32'(b_rsp0_valid), 0);
            check("t4_we", 32'(b_we), 0);
            step();
        end
        check("t4_rsp0", 32'(b_rsp0_valid), 1);
        check("t4_rdata0", b_rsp0_rdata, 32'h0000_1234);
        check("t4_rsp1", 32'(b_rsp1_valid), 0);
        check("t4_addr_resp", 32'(b_addr), 0);
        step();
        check("t4_rsp0_after", 32'(b_rsp0_valid), 0);
        check("t4_idle", 32'(b_busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
